// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   state_t     : scanner FSM states (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   ROW_INIT    : row drive after reset (row 0 driven low)
//   COL_IDLE    : column value with no key pressed (pulled up)
//   onehot0_low : true when exactly one of four active-low bits is low
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] ROW_INIT = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  function automatic logic onehot0_low(logic [3:0] c);
    logic [3:0] l;
    l = ~c;
    // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit set.
    return (l != 4'b0000) && ((l & (l - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/scan_tick.sv
// scan_tick: free-running divider for the keypad scanner.
//   Parameter SCAN_DIV : period of tick in clocks (>= 2).
//   clk  in  system clock
//   rst  in  asynchronous active-high reset, count returns to 0
//   tick out high on the last clock of every SCAN_DIV-clock period
module scan_tick #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan controller with press/release debounce.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat strobes while a key is held).
//   Parameters: SCAN_DIV (clocks per row dwell/sample), DEBOUNCE_CNT (matching samples
//               to accept press or release), REPEAT_CNT (ticks between repeat strobes).
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   col        in  [3:0] keypad columns, active-low, already synchronised
//   row        out [3:0] row drive, active-low, exactly one bit low
//   key_row    out [3:0] active-low row of the accepted key
//   key_col    out [3:0] active-low column of the accepted key
//   key_strobe out one-clock pulse per accepted key (and per repeat when enabled)
//   key_held   out high from accept until the release is debounced
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_CNT   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_strobe,
  output logic       key_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CNT);

  logic w_tick;

  scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_row, w_row_nxt;
  logic [3:0]       r_cand_col, w_cand_col_nxt;
  logic [3:0]       r_key_row, w_key_row_nxt;
  logic [3:0]       r_key_col, w_key_col_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             r_held, w_held_nxt;
  logic [3:0]       w_row_rot;
  logic             w_cand_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CNT);
  logic [REP_W-1:0] r_rep, w_rep_nxt;
`endif

  assign w_row_rot  = {r_row[2:0], r_row[3]};
  // The candidate's column line is low, whatever the other columns do.
  assign w_cand_low = (~(col | r_cand_col)) != 4'b0000;

  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_cand_col_nxt = r_cand_col;
    w_key_row_nxt  = r_key_row;
    w_key_col_nxt  = r_key_col;
    w_cnt_nxt      = r_cnt;
    w_strobe_nxt   = 1'b0;
    w_held_nxt     = r_held;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt      = r_rep;
`endif
    unique case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (onehot0_low(col)) begin
            // Row stays frozen on the candidate while it is debounced.
            w_cand_col_nxt = col;
            if (DEB_MAX == CNT_W'(1)) begin
              w_state_nxt   = PRESSED;
              w_key_row_nxt = r_row;
              w_key_col_nxt = col;
              w_strobe_nxt  = 1'b1;
              w_held_nxt    = 1'b1;
              w_cnt_nxt     = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt     = '0;
`endif
            end else begin
              w_state_nxt = DEBOUNCE;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else begin
            // Idle or ghost/multi-key sample: keep scanning.
            w_row_nxt = w_row_rot;
          end
        end
      end
      DEBOUNCE: begin
        if (w_tick) begin
          if (col == r_cand_col) begin
            if (r_cnt + CNT_W'(1) == DEB_MAX) begin
              w_state_nxt   = PRESSED;
              w_key_row_nxt = r_row;
              w_key_col_nxt = r_cand_col;
              w_strobe_nxt  = 1'b1;
              w_held_nxt    = 1'b1;
              w_cnt_nxt     = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt     = '0;
`endif
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            // Rotation resumes from the frozen row on the next tick.
            w_state_nxt = SCAN;
            w_cnt_nxt   = '0;
          end
        end
      end
      PRESSED: begin
        if (w_tick) begin
          if (col == COL_IDLE) begin
            if (DEB_MAX == CNT_W'(1)) begin
              w_state_nxt = SCAN;
              w_held_nxt  = 1'b0;
              w_row_nxt   = w_row_rot;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = RELEASE;
              w_cnt_nxt   = CNT_W'(1);
            end
`ifdef KEYPAD_REPEAT_EN
            w_rep_nxt = '0;
          end else if (w_cand_low) begin
            if (r_rep + REP_W'(1) == REP_MAX) begin
              w_strobe_nxt = 1'b1;
              w_rep_nxt    = '0;
            end else begin
              w_rep_nxt = r_rep + REP_W'(1);
            end
`endif
          end
        end
      end
      RELEASE: begin
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt = '0;
`endif
        if (w_tick) begin
          if (col == COL_IDLE) begin
            if (r_cnt + CNT_W'(1) == DEB_MAX) begin
              w_state_nxt = SCAN;
              w_held_nxt  = 1'b0;
              w_row_nxt   = w_row_rot;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else if (w_cand_low) begin
            // Release bounce: key is still down, no new strobe.
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SCAN;
      r_row      <= ROW_INIT;
      r_cand_col <= COL_IDLE;
      r_key_row  <= COL_IDLE;
      r_key_col  <= COL_IDLE;
      r_cnt      <= '0;
      r_strobe   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_cand_col <= w_cand_col_nxt;
      r_key_row  <= w_key_row_nxt;
      r_key_col  <= w_key_col_nxt;
      r_cnt      <= w_cnt_nxt;
      r_strobe   <= w_strobe_nxt;
      r_held     <= w_held_nxt;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_rep_nxt;
    end
  end
`endif

  assign row        = r_row;
  assign key_row    = r_key_row;
  assign key_col    = r_key_col;
  assign key_strobe = r_strobe;
  assign key_held   = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=5. Repeat checks run when KEYPAD_REPEAT_EN
// is defined.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_strobe;
  logic       key_held;

  // Keypad model: a pressed key pulls its column low only while its row is driven.
  logic       use_key;
  logic [3:0] p_row;
  logic [3:0] p_col;
  logic [3:0] raw_col;

  int total = 0;
  int bad   = 0;
  int ecount = 0;
  int nstrobe = 0;

  assign col = use_key ? ((row == p_row) ? p_col : 4'b1111) : raw_col;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3),
    .REPEAT_CNT  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_strobe(key_strobe),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; an edge where ecount becomes a multiple of 4 is a tick.
  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  always @(posedge clk) begin
    if (key_strobe) nstrobe <= nstrobe + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge right after the next tick edge.
  task automatic next_tick;
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while ((ecount % 4) != 0 && k < 8);
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  initial begin
    int s0;
    int found;
    logic [3:0] r0;

    rst = 1'b1;
    use_key = 1'b0;
    raw_col = 4'b1111;
    p_row = 4'b1111;
    p_col = 4'b1111;
    step(2);
    check4("rst_row", row, 4'b1110);
    check4("rst_key_row", key_row, 4'b1111);
    check4("rst_key_col", key_col, 4'b1111);
    check4("rst_strobe", {3'b0, key_strobe}, 4'b0000);
    check4("rst_held", {3'b0, key_held}, 4'b0000);
    rst = 1'b0;

    // Idle rotation, one step per 4 clocks.
    step(3);
    check4("rot_hold", row, 4'b1110);
    next_tick;
    check4("rot_1", row, 4'b1101);
    next_tick;
    check4("rot_2", row, 4'b1011);
    next_tick;
    check4("rot_3", row, 4'b0111);

    // Clean press of key 13 (row 0111, col 1110).
    p_row = 4'b0111;
    p_col = 4'b1110;
    use_key = 1'b1;
    s0 = nstrobe;
    next_tick;
    next_tick;
    step(3);
    check4("press_early", {3'b0, key_strobe}, 4'b0000);
    step(1);
    check4("press_strobe", {3'b0, key_strobe}, 4'b0001);
    check4("press_key_row", key_row, 4'b0111);
    check4("press_key_col", key_col, 4'b1110);
    check4("press_held", {3'b0, key_held}, 4'b0001);
    step(1);
    check4("press_strobe_1clk", {3'b0, key_strobe}, 4'b0000);
    checkn("press_count", nstrobe - s0, 1);

    // Release: held drops after the third idle tick, row advances one step.
    use_key = 1'b0;
    raw_col = 4'b1111;
    next_tick;
    next_tick;
    check4("rel_held_2", {3'b0, key_held}, 4'b0001);
    next_tick;
    check4("rel_held_3", {3'b0, key_held}, 4'b0000);
    check4("rel_row", row, 4'b1110);
    check4("rel_key_row_kept", key_row, 4'b0111);

    // Bounce: one matching sample, then idle.
    raw_col = 4'b1101;
    s0 = nstrobe;
    next_tick;
    check4("bounce_frozen", row, 4'b1110);
    raw_col = 4'b1111;
    next_tick;
    next_tick;
    next_tick;
    check4("bounce_resumed", {3'b0, (row !== 4'b1110)}, 4'b0001);
    checkn("bounce_no_strobe", nstrobe - s0, 0);
    check4("bounce_held", {3'b0, key_held}, 4'b0000);

    // Two keys on one sample: ignored, rotation continues.
    raw_col = 4'b1100;
    r0 = row;
    s0 = nstrobe;
    next_tick;
    check4("two_rot_1", row, rotl(r0));
    next_tick;
    check4("two_rot_2", row, rotl(rotl(r0)));
    step(1);
    checkn("two_no_strobe", nstrobe - s0, 0);

    // Long hold of key 1 (row 1110, col 1110).
    raw_col = 4'b1111;
    p_row = 4'b1110;
    p_col = 4'b1110;
    use_key = 1'b1;
    s0 = nstrobe;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step(1);
      if (key_held) found = 1;
    end
    checkn("hold_accepted", found, 1);
    check4("hold_strobe", {3'b0, key_strobe}, 4'b0001);
    check4("hold_key_row", key_row, 4'b1110);
    check4("hold_key_col", key_col, 4'b1110);
`ifdef KEYPAD_REPEAT_EN
    step(19);
    check4("rep_not_yet", {3'b0, key_strobe}, 4'b0000);
    step(1);
    check4("rep_strobe", {3'b0, key_strobe}, 4'b0001);
    check4("rep_key_row", key_row, 4'b1110);
`endif
    repeat (100) next_tick;
    check4("hold_still_held", {3'b0, key_held}, 4'b0001);
`ifndef KEYPAD_REPEAT_EN
    checkn("hold_one_strobe", nstrobe - s0, 1);
`endif
    use_key = 1'b0;
    next_tick;
    next_tick;
    check4("hold_rel_2", {3'b0, key_held}, 4'b0001);
    next_tick;
    check4("hold_rel_3", {3'b0, key_held}, 4'b0000);
    check4("hold_rel_row", row, 4'b1101);

    // Reset asserted while a candidate is being debounced.
    p_row = row;
    p_col = 4'b1011;
    use_key = 1'b1;
    next_tick;
    check4("mid_frozen", row, 4'b1101);
    #2 rst = 1'b1;
    #1;
    check4("mid_rst_row", row, 4'b1110);
    check4("mid_rst_key_row", key_row, 4'b1111);
    check4("mid_rst_key_col", key_col, 4'b1111);
    check4("mid_rst_strobe", {3'b0, key_strobe}, 4'b0000);
    check4("mid_rst_held", {3'b0, key_held}, 4'b0000);
    step(1);
    rst = 1'b0;
    use_key = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Clocked 4x4 keypad scan controller for the charge-phone front end. Drives the keypad row lines, samples the column lines, debounces press and release, and presents a stable active-low row/column pair plus a single-cycle strobe. That pair and strobe feed the existing key decoder's `R`, `C` and `startSet` inputs. Replaces direct wiring of raw keypad lines, so the decoder sees exactly one clean edge per physical press.

## Interface
- `SCAN_DIV`, default 1000: clocks per row dwell and per sample period; minimum 2.
- `DEBOUNCE_CNT`, default 8: consecutive identical samples needed to accept a press or a release; minimum 1.
- `REPEAT_CNT`, default 250: sample periods between auto-repeat strobes; used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `col`  in  4  keypad columns, active-low, externally pulled up; already synchronised upstream.
- `row`  out  4  keypad row drive, active-low, exactly one bit low at all times.
- `key_row`  out  4  latched active-low row of the accepted key (decoder `R`).
- `key_col`  out  4  latched active-low column of the accepted key (decoder `C`).
- `key_strobe`  out  1  one-clock pulse per accepted key (decoder `startSet`).
- `key_held`  out  1  high from accept until release is debounced.

## Operation
- **Reset values:**
  - `row`=1110, `key_row`=`key_col`=1111.
  - `key_strobe`=0, `key_held`=0.
  - State `SCAN`, all counters 0.
- **Sample tick:** `tick` pulses on the last clock of every `SCAN_DIV`-clock period. Columns are sampled only on `tick`, which gives `SCAN_DIV`-1 clocks of settling after a row change.
- **`SCAN`:**
  - On `tick` with `col`=1111, rotate `row` left (1110→1101→1011→0111→1110).
  - On `tick` with exactly one `col` bit low, capture `row`/`col` as the candidate, set match count to 1, freeze `row`, go to `DEBOUNCE`.
  - On `tick` with two or more `col` bits low (ghost or multi-key), ignore the sample and keep rotating.
- **`DEBOUNCE`:**
  - On each `tick`, if `col` equals the candidate, increment the count. Otherwise return to `SCAN` and resume rotation from the frozen row.
  - When the count reaches `DEBOUNCE_CNT`, go to `PRESSED`.
  - With `DEBOUNCE_CNT`=1, the first sample is accepted immediately.
- **Entry to `PRESSED`:**
  - Load `key_row`/`key_col` from the candidate.
  - Pulse `key_strobe` for one clock.
  - Set `key_held`=1.
- **`PRESSED`:**
  - On `tick` with `col`=1111, set release count to 1 and go to `RELEASE`.
  - Any other `col` value, including a different key, is ignored; `row` stays frozen.
- **`RELEASE`:**
  - On `tick` with `col`=1111, increment the release count. At `DEBOUNCE_CNT`, clear `key_held`, advance `row` one step and go to `SCAN`.
  - On `tick` with the candidate column low again, return to `PRESSED` with no new strobe.
- **`key_row`/`key_col`:** hold their value until the next accept. They are never returned to 1111 except by reset.
- **Reset mid-operation:** `rst` at any point returns every output to its reset value asynchronously. A strobe in progress is truncated.

## Timing
- `row` changes only on the clock after a `tick`.
- **Press latency:** from the first accepting sample, `key_strobe` asserts exactly (`DEBOUNCE_CNT`-1)×`SCAN_DIV`+1 clocks later. It asserts in the clock after the `DEBOUNCE_CNT`-th matching `tick`.
- **Outputs at strobe:** `key_row`/`key_col` are valid in the same clock as `key_strobe` and remain stable afterwards. The decoder may therefore register them on the strobe's rising edge.
- **Minimum spacing:** two strobes are separated by at least 2×`DEBOUNCE_CNT`×`SCAN_DIV` clocks, unless auto-repeat is enabled.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - In `PRESSED`, a repeat counter counts ticks while the candidate column stays low.
  - Each time the counter reaches `REPEAT_CNT`, pulse `key_strobe` once (`key_row`/`key_col` unchanged) and reset the counter to 0.
  - The counter clears on entry to `PRESSED` and in `RELEASE`.
- **`KEYPAD_REPEAT_EN` undefined:** exactly one strobe per press; no repeat counter is synthesised.

## Structure
- **Shared package `keypad_pkg`:**
  - State enum `SCAN`, `DEBOUNCE`, `PRESSED`, `RELEASE`.
  - Constants `ROW_INIT`=1110 and `COL_IDLE`=1111.
  - Function `onehot0_low(col)` returning true if exactly one bit is low.
- **Sub-module `scan_tick`:** parameterised by `SCAN_DIV`; free-running divider producing `tick`, reset to count 0.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CNT`=3.
- **Reset:** assert `rst` -> `row`=1110, `key_row`=`key_col`=1111, `key_strobe`=0, `key_held`=0; with `col`=1111 and no press, `row` cycles 1110→1101→1011→0111, one step per 4 clocks.
- **Clean press:** hold `col`=1110 while `row`=0111 -> one `key_strobe` 9 clocks after the first accepting tick; `key_row`=0111, `key_col`=1110 (decoder key 13, enter); `key_held`=1.
- **Bounce:** `col`=1101 for 1 tick, then 1111 -> no strobe; back in `SCAN` with rotation resumed.
- **Two keys:** `col`=1100 -> no strobe; `row` keeps rotating.
- **Long hold then release:** hold key 1 (`row`=1110, `col`=1110) for 100 ticks, then release -> exactly one strobe without the macro; `key_held` drops after 3 idle ticks.
- **Repeat and reset:** with `KEYPAD_REPEAT_EN` and `REPEAT_CNT`=5, hold a key -> a strobe every 20 clocks after the first. Assert `rst` mid-`DEBOUNCE` -> all outputs return to reset values immediately.
